// File: rtl/thumb_prefetch_unit_if.sv
// thumb_prefetch_unit_if: memory, issue and redirect signals; master = prefetch unit, slave = memory/decoder side
interface thumb_prefetch_unit_if #(
  parameter int MEM_AW = 10
);
  logic              mem_req;
  logic [MEM_AW-1:0] mem_addr;
  logic              mem_ready;
  logic [31:0]       mem_rdata;
  logic              out_valid;
  logic [31:0]       out_instr;
  logic              out_is32;
  logic [31:0]       out_pc;
  logic              out_ready;
  logic              br_valid;
  logic [31:0]       br_target;
  modport master (
    output mem_req, mem_addr, out_valid, out_instr, out_is32, out_pc,
    input  mem_ready, mem_rdata, out_ready, br_valid, br_target
  );
  modport slave (
    input  mem_req, mem_addr, out_valid, out_instr, out_is32, out_pc,
    output mem_ready, mem_rdata, out_ready, br_valid, br_target
  );
endinterface

// File: rtl/thumb_prefetch_unit.sv
// thumb_prefetch_unit: word fetch -> halfword queue -> Thumb/BL issue; ports clock, reset (async, high), bus (master)
module thumb_prefetch_unit #(
  parameter int          DEPTH    = 4,
  parameter int          MEM_AW   = 10,
  parameter logic [31:0] RESET_PC = 32'h0,
  parameter bit          PAIR_BL  = 1'b1
) (
  input logic                   clock,
  input logic                   reset,
  thumb_prefetch_unit_if.master bus
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] ONE = (AW+1)'(1);
  localparam logic [AW:0] TWO = (AW+1)'(2);
  localparam logic [AW:0] CAP = (AW+1)'(DEPTH);
  typedef enum logic [1:0] {IDLE, REQ, FLUSH} state_t;
  state_t        state_q, state_d;
  logic [31:0]   fetch_pc_q, fetch_pc_d;
  logic [15:0]   hw_q [DEPTH];
  logic [15:0]   hw_d [DEPTH];
  logic [31:0]   pc_q [DEPTH];
  logic [31:0]   pc_d [DEPTH];
  logic [AW-1:0] head_q, head_d, tail_q, tail_d, head_n, hi_slot;
  logic [AW:0]   count_q, count_d, free, n_enq, n_deq;
  logic          prefix, accept, take;
  assign head_n         = head_q + 1'b1;
  assign hi_slot        = fetch_pc_q[1] ? tail_q : tail_q + 1'b1;
  assign prefix         = PAIR_BL && hw_q[head_q][15:11] == 5'b11110;
  assign free           = CAP - count_q;
  assign accept         = state_q == REQ && bus.mem_ready && !bus.br_valid;
  assign take           = bus.out_valid && bus.out_ready;
  assign bus.mem_req    = state_q == REQ;
  assign bus.mem_addr   = fetch_pc_q[MEM_AW+1:2];
  assign bus.out_valid  = count_q != '0 && (!prefix || count_q >= TWO);
  assign bus.out_is32   = bus.out_valid && prefix;
  assign bus.out_instr  = !bus.out_valid ? 32'h0 : prefix ? {hw_q[head_q], hw_q[head_n]} : {16'h0, hw_q[head_q]};
  assign bus.out_pc     = bus.out_valid ? pc_q[head_q] : 32'h0;
  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    hw_d       = hw_q;
    pc_d       = pc_q;
    n_enq      = accept ? (fetch_pc_q[1] ? ONE : TWO) : '0;
    n_deq      = take ? (prefix ? TWO : ONE) : '0;
    if (accept && !fetch_pc_q[1]) begin
      hw_d[tail_q] = bus.mem_rdata[15:0];
      pc_d[tail_q] = {fetch_pc_q[31:2], 2'b00};
    end
    if (accept) begin
      hw_d[hi_slot] = bus.mem_rdata[31:16];
      pc_d[hi_slot] = {fetch_pc_q[31:2], 2'b10};
      fetch_pc_d    = {fetch_pc_q[31:2] + 30'd1, 2'b00};
    end
    head_d  = head_q + n_deq[AW-1:0];
    tail_d  = tail_q + n_enq[AW-1:0];
    count_d = count_q + n_enq - n_deq;
    state_d = state_q == IDLE ? (free >= TWO ? REQ : IDLE) : (state_q == REQ && !bus.mem_ready) ? REQ : IDLE;
    if (bus.br_valid) begin
      state_d    = FLUSH;
      fetch_pc_d = bus.br_target & ~32'h1;
      head_d     = '0;
      tail_d     = '0;
      count_d    = '0;
    end
  end
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      fetch_pc_q <= RESET_PC & ~32'h1;
      hw_q       <= '{default: '0};
      pc_q       <= '{default: '0};
      head_q     <= '0;
      tail_q     <= '0;
      count_q    <= '0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      hw_q       <= hw_d;
      pc_q       <= pc_d;
      head_q     <= head_d;
      tail_q     <= tail_d;
      count_q    <= count_d;
    end
  end
endmodule
